// File: rtl/data_cache_pkg.sv
// Shared definitions for the direct-mapped data cache: geometry and controller states.
package data_cache_pkg;

    localparam int CACHE_LINES = 16;
    localparam int INDEX_W     = 4;
    localparam int TAG_W       = 12;
    localparam int WORD_W      = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2,
        DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/data_cache_if.sv
// Pipeline-side and main-memory-side signals of the data cache in one bundle.
interface data_cache_if
    import data_cache_pkg::*;
    ();
    logic [WORD_W-1:0] inp_address;
    logic [WORD_W-1:0] inp_writeData;
    logic              inp_memRead;
    logic              inp_memWrite;
    logic [WORD_W-1:0] out_readData;
    logic              out_hit;
    logic [WORD_W-1:0] out_memAddress;
    logic [WORD_W-1:0] out_memWriteData;
    logic              out_memRead;
    logic              out_memWrite;
    logic [WORD_W-1:0] inp_memData;
    logic              inp_memReady;

    modport slave (
        input  inp_address, inp_writeData, inp_memRead, inp_memWrite,
        input  inp_memData, inp_memReady,
        output out_readData, out_hit, out_memAddress, out_memWriteData,
        output out_memRead, out_memWrite
    );

    modport master (
        output inp_address, inp_writeData, inp_memRead, inp_memWrite,
        output inp_memData, inp_memReady,
        input  out_readData, out_hit, out_memAddress, out_memWriteData,
        input  out_memRead, out_memWrite
    );
endinterface

// File: rtl/data_cache_cache_array.sv
// Line storage: valid/tag/data per line, combinational read, synchronous write and valid clear.
module cache_array
    import data_cache_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_srst,
    input  logic [INDEX_W-1:0] i_rd_index,
    output logic               o_rd_valid,
    output logic [TAG_W-1:0]   o_rd_tag,
    output logic [WORD_W-1:0]  o_rd_data,
    input  logic               i_wr_en,
    input  logic [INDEX_W-1:0] i_wr_index,
    input  logic [TAG_W-1:0]   i_wr_tag,
    input  logic [WORD_W-1:0]  i_wr_data
);
    logic [TAG_W-1:0]       r_tag  [CACHE_LINES];
    logic [WORD_W-1:0]      r_data [CACHE_LINES];
    logic [CACHE_LINES-1:0] w_valid;

    // Tag and data deliberately have no reset; only the valid bits matter after reset.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_tag[i_wr_index]  <= i_wr_tag;
            r_data[i_wr_index] <= i_wr_data;
        end
    end

    generate
        for (genvar gi = 0; gi < CACHE_LINES; gi++) begin : g_valid
            logic r_valid;
            always_ff @(posedge i_clk) begin
                if (i_srst) begin
                    r_valid <= 1'b0;
                end else if (i_wr_en && (i_wr_index == INDEX_W'(gi))) begin
                    r_valid <= 1'b1;
                end
            end
            assign w_valid[gi] = r_valid;
        end
    endgenerate

    assign o_rd_valid = w_valid[i_rd_index];
    assign o_rd_tag   = r_tag[i_rd_index];
    assign o_rd_data  = r_data[i_rd_index];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with zero-cycle read hits.
module data_cache
    import data_cache_pkg::*;
(
    input  logic         inp_clk,
    input  logic         inp_reset,
    data_cache_if.slave  bus
);
    state_t             r_state;
    logic [WORD_W-1:0]  r_addr;
    logic [WORD_W-1:0]  r_wdata;
    logic [WORD_W-1:0]  r_readData;
    logic               r_memRead;
    logic               r_memWrite;

    logic [INDEX_W-1:0] w_index;
    logic [TAG_W-1:0]   w_cmp_tag;
    logic               w_line_valid;
    logic [TAG_W-1:0]   w_line_tag;
    logic [WORD_W-1:0]  w_line_data;
    logic               w_tag_match;
    logic               w_read_hit;
    logic               w_wr_en;
    logic [WORD_W-1:0]  w_wr_data;
    logic               w_hit;

    // Look up the incoming address in IDLE, the latched one while an access is outstanding.
    assign w_index     = (r_state == IDLE) ? bus.inp_address[INDEX_W-1:0] : r_addr[INDEX_W-1:0];
    assign w_cmp_tag   = (r_state == IDLE) ? bus.inp_address[WORD_W-1:INDEX_W] : r_addr[WORD_W-1:INDEX_W];
    assign w_tag_match = w_line_valid && (w_line_tag == w_cmp_tag);
    assign w_read_hit  = (r_state == IDLE) && bus.inp_memRead && !bus.inp_memWrite && w_tag_match;

    assign w_wr_en   = !inp_reset && bus.inp_memReady &&
                       ((r_state == RD_WAIT) || ((r_state == WR_WAIT) && w_tag_match));
    assign w_wr_data = (r_state == RD_WAIT) ? bus.inp_memData : r_wdata;

    cache_array u_array (
        .i_clk      (inp_clk),
        .i_srst     (inp_reset),
        .i_rd_index (w_index),
        .o_rd_valid (w_line_valid),
        .o_rd_tag   (w_line_tag),
        .o_rd_data  (w_line_data),
        .i_wr_en    (w_wr_en),
        .i_wr_index (r_addr[INDEX_W-1:0]),
        .i_wr_tag   (r_addr[WORD_W-1:INDEX_W]),
        .i_wr_data  (w_wr_data)
    );

    always_ff @(posedge inp_clk) begin
        if (inp_reset) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_readData <= '0;
            r_memRead  <= 1'b0;
            r_memWrite <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.inp_memWrite) begin
                        r_addr     <= bus.inp_address;
                        r_wdata    <= bus.inp_writeData;
                        r_memWrite <= 1'b1;
                        r_state    <= WR_WAIT;
                    end else if (bus.inp_memRead && !w_read_hit) begin
                        r_addr    <= bus.inp_address;
                        r_wdata   <= bus.inp_writeData;
                        r_memRead <= 1'b1;
                        r_state   <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (bus.inp_memReady) begin
                        r_readData <= bus.inp_memData;
                        r_memRead  <= 1'b0;
                        r_state    <= DONE;
                    end
                end
                WR_WAIT: begin
                    if (bus.inp_memReady) begin
                        r_memWrite <= 1'b0;
                        r_state    <= DONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        w_hit = 1'b0;
        case (r_state)
            IDLE:    w_hit = !(bus.inp_memRead || bus.inp_memWrite) || w_read_hit;
            DONE:    w_hit = 1'b1;
            default: w_hit = 1'b0;
        endcase
    end

    assign bus.out_hit          = w_hit;
    assign bus.out_readData     = w_read_hit ? w_line_data : r_readData;
    assign bus.out_memAddress   = r_addr;
    assign bus.out_memWriteData = r_wdata;
    assign bus.out_memRead      = r_memRead;
    assign bus.out_memWrite     = r_memWrite;

endmodule

// File: tb/tb_data_cache.sv
// Bench for data_cache: directed vector table, reset-abort sequence, random traffic vs. reference model.
module tb_data_cache;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_cache_if bus ();

    data_cache dut (
        .inp_clk   (clk),
        .inp_reset (rst),
        .bus       (bus)
    );

    int n_checks = 0;
    int n_err    = 0;
    int n_tx     = 0;

    // Reference model: backing memory plus what each of the 16 slots currently holds.
    logic [15:0] mem [logic [15:0]];
    bit          m_valid [16];
    logic [15:0] m_addr  [16];
    logic [15:0] m_data  [16];

    typedef struct {
        bit          wr;
        bit          rd;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          lat;
        bit          exp_hit;
        logic [15:0] exp_data;
    } vec_t;

    vec_t vecs [$];

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        return mem.exists(a) ? mem[a] : (a ^ 16'h5A3C);
    endfunction

    function automatic bit model_hit(input logic [15:0] a);
        return m_valid[a % 16] && (m_addr[a % 16] == a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_junk();
        bus.inp_address   = 16'($urandom);
        bus.inp_writeData = 16'($urandom);
        bus.inp_memRead   = 1'($urandom);
        bus.inp_memWrite  = 1'($urandom);
    endtask

    task automatic access(input bit wr, input bit rd, input logic [15:0] addr,
                          input logic [15:0] wdata, input int lat,
                          input bit exp_hit, input logic [15:0] exp_data);
        bit was_hit;
        was_hit = model_hit(addr);
        @(negedge clk);
        bus.inp_address   = addr;
        bus.inp_writeData = wdata;
        bus.inp_memRead   = rd;
        bus.inp_memWrite  = wr;
        bus.inp_memReady  = 1'($urandom);
        bus.inp_memData   = 16'($urandom);
        #1;
        if (!wr && !rd) begin
            check("idle_status", {29'd0, bus.out_hit, bus.out_memRead, bus.out_memWrite}, 32'b100);
        end else if (exp_hit) begin
            check("hit_status", {29'd0, bus.out_hit, bus.out_memRead, bus.out_memWrite}, 32'b100);
            check("hit_data", {16'd0, bus.out_readData}, {16'd0, exp_data});
        end else begin
            check("req_stall", {29'd0, bus.out_hit, bus.out_memRead, bus.out_memWrite}, 32'b000);
            for (int c = 1; c <= lat; c++) begin
                @(negedge clk);
                drive_junk();
                bus.inp_memReady = (c == lat);
                bus.inp_memData  = (c == lat) ? mem_rd(addr) : 16'($urandom);
                #1;
                check(wr ? "wr_wait_status" : "rd_wait_status",
                      {29'd0, bus.out_hit, bus.out_memRead, bus.out_memWrite},
                      wr ? 32'b001 : 32'b010);
                check("wait_addr", {16'd0, bus.out_memAddress}, {16'd0, addr});
                if (wr) check("wait_wdata", {16'd0, bus.out_memWriteData}, {16'd0, wdata});
            end
            @(negedge clk);
            drive_junk();
            bus.inp_memReady = 1'($urandom);
            bus.inp_memData  = 16'($urandom);
            #1;
            check("done_status", {29'd0, bus.out_hit, bus.out_memRead, bus.out_memWrite}, 32'b100);
            if (!wr) check("done_data", {16'd0, bus.out_readData}, {16'd0, exp_data});
        end
        if (wr) begin
            mem[addr] = wdata;
            if (was_hit) m_data[addr % 16] = wdata;
        end else if (rd && !was_hit) begin
            m_valid[addr % 16] = 1'b1;
            m_addr[addr % 16]  = addr;
            m_data[addr % 16]  = mem_rd(addr);
        end
        n_tx++;
        $display("tx %0d wr=%0b rd=%0b addr=%h wdata=%h lat=%0d exp_hit=%0b exp_data=%h",
                 n_tx, wr, rd, addr, wdata, lat, exp_hit, exp_data);
    endtask

    initial begin
        bus.inp_address   = '0;
        bus.inp_writeData = '0;
        bus.inp_memRead   = 1'b0;
        bus.inp_memWrite  = 1'b0;
        bus.inp_memData   = '0;
        bus.inp_memReady  = 1'b0;
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        mem[16'h0012] = 16'hBEEF;
        mem[16'h0022] = 16'h1234;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_status", {29'd0, bus.out_hit, bus.out_memRead, bus.out_memWrite}, 32'b100);
        check("rst_memaddr", {16'd0, bus.out_memAddress}, 32'd0);
        check("rst_memwdata", {16'd0, bus.out_memWriteData}, 32'd0);
        check("rst_rdata", {16'd0, bus.out_readData}, 32'd0);

        vecs.push_back('{1'b0, 1'b1, 16'h0012, 16'h0000, 3, 1'b0, 16'hBEEF});
        vecs.push_back('{1'b0, 1'b1, 16'h0012, 16'h0000, 1, 1'b1, 16'hBEEF});
        vecs.push_back('{1'b0, 1'b1, 16'h0022, 16'h0000, 2, 1'b0, 16'h1234});
        vecs.push_back('{1'b0, 1'b1, 16'h0012, 16'h0000, 1, 1'b0, 16'hBEEF});
        vecs.push_back('{1'b0, 1'b1, 16'h0022, 16'h0000, 1, 1'b0, 16'h1234});
        vecs.push_back('{1'b1, 1'b0, 16'h0022, 16'h5555, 2, 1'b0, 16'h0000});
        vecs.push_back('{1'b0, 1'b1, 16'h0022, 16'h0000, 1, 1'b1, 16'h5555});
        vecs.push_back('{1'b1, 1'b0, 16'h0033, 16'h7777, 1, 1'b0, 16'h0000});
        vecs.push_back('{1'b0, 1'b1, 16'h0033, 16'h0000, 2, 1'b0, 16'h7777});
        vecs.push_back('{1'b1, 1'b1, 16'h0044, 16'h0A0A, 2, 1'b0, 16'h0000});
        vecs.push_back('{1'b0, 1'b1, 16'h0044, 16'h0000, 1, 1'b0, 16'h0A0A});
        vecs.push_back('{1'b0, 1'b0, 16'h0000, 16'h0000, 1, 1'b1, 16'h0000});
        vecs.push_back('{1'b0, 1'b1, 16'h0044, 16'h0000, 1, 1'b1, 16'h0A0A});

        foreach (vecs[i])
            access(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata,
                   vecs[i].lat, vecs[i].exp_hit, vecs[i].exp_data);

        // Reset landing in the second RD_WAIT cycle, with memReady high on that same edge.
        @(negedge clk);
        bus.inp_address  = 16'h0055;
        bus.inp_memRead  = 1'b1;
        bus.inp_memWrite = 1'b0;
        bus.inp_memReady = 1'b0;
        #1;
        check("abort_c0", {29'd0, bus.out_hit, bus.out_memRead, bus.out_memWrite}, 32'b000);
        @(negedge clk);
        #1;
        check("abort_c1", {29'd0, bus.out_hit, bus.out_memRead, bus.out_memWrite}, 32'b010);
        @(negedge clk);
        rst = 1'b1;
        bus.inp_memReady = 1'b1;
        bus.inp_memData  = 16'hDEAD;
        #1;
        check("abort_c2", {29'd0, bus.out_hit, bus.out_memRead, bus.out_memWrite}, 32'b010);
        @(negedge clk);
        rst = 1'b0;
        bus.inp_memRead  = 1'b0;
        bus.inp_memReady = 1'b0;
        #1;
        check("abort_after", {29'd0, bus.out_hit, bus.out_memRead, bus.out_memWrite}, 32'b100);
        check("abort_memaddr", {16'd0, bus.out_memAddress}, 32'd0);
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        access(1'b0, 1'b1, 16'h0055, 16'h0000, 2, 1'b0, mem_rd(16'h0055));
        access(1'b0, 1'b1, 16'h0044, 16'h0000, 1, 1'b0, 16'h0A0A);

        for (int t = 0; t < 200; t++) begin
            logic [15:0] a;
            logic [15:0] d;
            int          k;
            int          lat;
            bit          wr;
            bit          rd;
            bit          eh;
            a = 16'(($urandom_range(0, 2) << 4) | $urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) a[15] = 1'b1;
            d   = 16'($urandom);
            k   = $urandom_range(0, 7);
            lat = $urandom_range(1, 4);
            wr  = (k >= 5);
            rd  = (k >= 1 && k <= 4) || (k == 7);
            eh  = rd && !wr && model_hit(a);
            access(wr, rd, a, d, lat, eh,
                   model_hit(a) ? m_data[a % 16] : mem_rd(a));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
